// File: rtl/vector_mem_responder.sv
// vector_mem_responder
// Memory-side responder for the vector load/store port. Accepts one
// vector-wide load or store per cycle, applies per-byte write enables to a
// local storage array and returns load data in request order through a
// fixed-latency read pipeline and a credit-protected response FIFO.
//
// Build option: define VECTOR_MEM_WRITE_ACK_EN to make every store return
// one acknowledge beat (resp_is_write=1, sdata=0) in request order.
module vector_mem_responder #(
    parameter int NUM_ELEMS    = 8,
    parameter int ELEM_SIZE    = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_we,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [NUM_ELEMS*ELEM_SIZE-1:0]       mdata,
    input  logic [NUM_ELEMS*ELEM_SIZE/8-1:0]     mbyteen,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic                                 resp_is_write,
    output logic [NUM_ELEMS*ELEM_SIZE-1:0]       sdata,
    output logic                                 busy
);

    localparam int          W     = NUM_ELEMS * ELEM_SIZE;
    localparam int unsigned B     = W / 8;
    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam int          CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int          PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

`ifdef VECTOR_MEM_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif

    logic [W-1:0]       mem [DEPTH];
    logic               reset_d;
    logic [CNT_W-1:0]   outstanding;
    logic               credit_ok;
    logic               accept;
    logic               produce;
    logic               pop;

    logic               head_valid;
    logic               head_write;
    logic [W-1:0]       head_data;
    logic               tail_valid;
    logic               tail_write;
    logic [W-1:0]       tail_data;

    logic [W-1:0]       fifo_data [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] fifo_wr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stores that return no beat bypass the credit check; this looks at
    // req_we but never at req_valid, so there is no valid->ready path.
    assign credit_ok = (outstanding < CNT_W'(RESP_DEPTH));
    assign req_ready = !reset_d && (credit_ok || (!WRITE_ACK && req_we));
    assign accept    = req_valid && req_ready && !reset;
    assign produce   = accept && (!req_we || WRITE_ACK);
    assign pop       = resp_valid && resp_ready;
    assign busy      = (outstanding != '0);

    // Registered copy of reset holds req_ready low for the reset cycle.
    always_ff @(posedge clk) begin
        reset_d <= reset;
    end

    // Byte-masked store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            for (int unsigned j = 0; j < B; j++) begin
                if (mbyteen[j]) begin
                    mem[req_addr][8*j +: 8] <= mdata[8*j +: 8];
                end
            end
        end
    end

    // A store writes at its accept edge, so a load in the next cycle
    // already reads the new bytes.
    assign head_valid = produce;
    assign head_write = req_we;
    assign head_data  = req_we ? '0 : mem[req_addr];

    // The FIFO write is the last of the READ_LATENCY register stages, so
    // only READ_LATENCY-1 stages sit between the array and the FIFO.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_valid = head_valid;
            assign tail_write = head_write;
            assign tail_data  = head_data;
        end else begin : g_pipe
            logic [READ_LATENCY-2:0] pipe_valid;
            logic [READ_LATENCY-2:0] pipe_write;
            logic [W-1:0]            pipe_data [READ_LATENCY-1];

            // Valid bits of the read pipeline; flushed on reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= head_valid;
                    for (int unsigned i = 1; i < READ_LATENCY - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // Payload of the read pipeline; qualified by pipe_valid.
            always_ff @(posedge clk) begin
                pipe_write[0] <= head_write;
                pipe_data[0]  <= head_data;
                for (int unsigned i = 1; i < READ_LATENCY - 1; i++) begin
                    pipe_write[i] <= pipe_write[i-1];
                    pipe_data[i]  <= pipe_data[i-1];
                end
            end

            assign tail_valid = pipe_valid[READ_LATENCY-2];
            assign tail_write = pipe_write[READ_LATENCY-2];
            assign tail_data  = pipe_data[READ_LATENCY-2];
        end
    endgenerate

    // Response FIFO storage; space is guaranteed by the credit counter.
    always_ff @(posedge clk) begin
        if (tail_valid) begin
            fifo_data[wr_ptr] <= tail_data;
            fifo_wr[wr_ptr]   <= tail_write;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (tail_valid) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({tail_valid, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credits: beats in the read pipeline plus beats waiting in the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({produce, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign resp_valid    = (count != '0);
    assign sdata         = resp_valid ? fifo_data[rd_ptr] : '0;
    assign resp_is_write = WRITE_ACK && resp_valid && fifo_wr[rd_ptr];

endmodule

// File: tb/tb_vector_mem_responder.sv
// Self-checking bench for vector_mem_responder: a queue-based reference
// model checked every cycle, directed scenarios with literal expectations,
// then randomized traffic. Honours VECTOR_MEM_WRITE_ACK_EN like the design.
`timescale 1ns/1ps
module tb_vector_mem_responder;

    localparam int NE = 8;
    localparam int ES = 16;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int RD = RL + 1;
    localparam int W  = NE * ES;
    localparam int B  = W / 8;

`ifdef VECTOR_MEM_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  mdata;
    logic [B-1:0]  mbyteen;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_is_write;
    logic [W-1:0]  sdata;
    logic          busy;

    always #5 clk = ~clk;

    vector_mem_responder #(
        .NUM_ELEMS   (NE),
        .ELEM_SIZE   (ES),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .RESP_DEPTH  (RD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .mdata        (mdata),
        .mbyteen      (mbyteen),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_is_write(resp_is_write),
        .sdata        (sdata),
        .busy         (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         wr;
        int           vis;   // first edge after which the beat is visible
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] mem_m [64];
    int           checks  = 0;
    int           errors  = 0;
    int           edge_n  = 0;
    bit           m_known = 1'b0;
    logic         m_rst_d = 1'b1;
    bit           m_acc   = 1'b0;
    int           run     = 0;
    int           max_run = 0;
    int           beats   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: compare at negedge, then advance for the next edge.
    initial begin
        logic         exp_valid;
        logic         exp_ready;
        logic [W-1:0] exp_data;
        logic         exp_wr;
        beat_t        nb;
        forever begin
            @(negedge clk);
            exp_valid = 1'b0;
            exp_ready = 1'b0;
            exp_data  = '0;
            exp_wr    = 1'b0;
            if (m_known) begin
                exp_valid = (q.size() != 0) && (q[0].vis <= edge_n);
                exp_data  = exp_valid ? q[0].data : '0;
                exp_wr    = exp_valid && q[0].wr;
                exp_ready = !m_rst_d && ((q.size() < RD) || (!ACK && req_we));
                chk("resp_valid", W'(resp_valid), W'(exp_valid));
                chk("sdata", sdata, exp_data);
                chk("resp_is_write", W'(resp_is_write), W'(exp_wr));
                chk("busy", W'(busy), W'(q.size() != 0));
                chk("req_ready", W'(req_ready), W'(exp_ready));
            end
            if (resp_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (resp_valid && resp_ready) beats++;

            m_acc = 1'b0;
            edge_n++;
            if (reset) begin
                q.delete();
                m_rst_d = 1'b1;
                m_known = 1'b1;
            end else if (m_known) begin
                if (exp_valid && resp_ready) void'(q.pop_front());
                if (req_valid && exp_ready) begin
                    m_acc = 1'b1;
                    nb.vis = edge_n + RL - 1;
                    if (req_we) begin
                        for (int j = 0; j < B; j++) begin
                            if (mbyteen[j]) mem_m[req_addr[5:0]][8*j +: 8] = mdata[8*j +: 8];
                        end
                        if (ACK) begin
                            nb.data = '0;
                            nb.wr   = 1'b1;
                            q.push_back(nb);
                        end
                    end else begin
                        nb.data = mem_m[req_addr[5:0]];
                        nb.wr   = 1'b0;
                        q.push_back(nb);
                    end
                end
                m_rst_d = 1'b0;
            end
        end
    end

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one request and hold it until the model reports acceptance.
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic [B-1:0] be);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        mdata     = d;
        mbyteen   = be;
        while (1) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
            n++;
            if (n > 50) begin
                note_fail("issue_timeout");
                break;
            end
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = 1'b0;
        while (q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                note_fail("drain_timeout");
                break;
            end
        end
    endtask

    // Wait for the next load beat; k counts negedges skipped before it.
    task automatic wait_load(output logic [W-1:0] d, output int k);
        k = 0;
        d = '0;
        while (k < 20) begin
            @(negedge clk);
            if (resp_valid && !resp_is_write) begin
                d = sdata;
                break;
            end
            k++;
        end
        if (k >= 20) note_fail("wait_load_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        int           k;
        int           acc_cnt;
        int           e0;
        int           exp_beats;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        mdata      = '0;
        mbyteen    = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", W'(req_ready), W'(1'b0));
        chk("rst_resp_valid", W'(resp_valid), W'(1'b0));
        chk("rst_busy", W'(busy), W'(1'b0));
        chk("rst_sdata", sdata, '0);
        chk("rst_resp_is_write", W'(resp_is_write), W'(1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_req_ready", W'(req_ready), W'(1'b1));
        @(posedge clk);
        #1;

        for (int a = 0; a < 64; a++) issue(1'b1, AW'(a), rnd_word(), '1);
        drain();

        // Store all-0xA5 then load the same word the next cycle.
        issue(1'b1, 10'h005, {16{8'hA5}}, '1);
        issue(1'b0, 10'h005, '0, '0);
        wait_load(d, k);
        chk("t1_data", d, {16{8'hA5}});
        chk("t1_latency", W'(k), W'(1));
        drain();

        // Partial store over an all-ones word.
        issue(1'b1, 10'h010, '1, '1);
        issue(1'b1, 10'h010, '0, 16'h00FF);
        issue(1'b0, 10'h010, '0, '0);
        wait_load(d, k);
        chk("t2_data", d, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        drain();

        // Backpressure: loads held while responses are refused.
        resp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(32 + acc_cnt);
            @(posedge clk);
            #1;
            if (m_acc) acc_cnt++;
        end
        chk("t3_accepted", W'(acc_cnt), W'(3));
        @(negedge clk);
        chk("t3_req_ready_low", W'(req_ready), W'(1'b0));
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();

        // Sixteen back-to-back loads with the consumer always ready.
        max_run = 0;
        e0 = edge_n;
        for (int i = 0; i < 16; i++) issue(1'b0, AW'(i), '0, '0);
        chk("t4_issue_cycles", W'(edge_n - e0), W'(16));
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t4_resp_run", W'(max_run), W'(16));

        // Reset with two loads pending; array contents must survive.
        resp_ready = 1'b0;
        issue(1'b0, 10'h003, '0, '0);
        issue(1'b0, 10'h004, '0, '0);
        chk("t5_busy_before", W'(busy), W'(1'b1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_resp_valid_after", W'(resp_valid), W'(1'b0));
        chk("t5_busy_after", W'(busy), W'(1'b0));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 10'h003, '0, '0);
        issue(1'b0, 10'h004, '0, '0);
        issue(1'b0, 10'h005, '0, '0);
        wait_load(d, k);
        drain();

        // Store followed by load: one or two beats depending on the build.
        beats = 0;
        issue(1'b1, 10'h028, rnd_word(), '1);
        issue(1'b0, 10'h028, '0, '0);
        drain();
        repeat (2) @(posedge clk);
        #1;
`ifdef VECTOR_MEM_WRITE_ACK_EN
        exp_beats = 2;
`else
        exp_beats = 1;
`endif
        chk("t6_beats", W'(beats), W'(exp_beats));

        // Randomized traffic, including random consumer stalls.
        for (int i = 0; i < 600; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, 63));
            mdata      = rnd_word();
            mbyteen    = B'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        note_fail("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
